// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
// Turns the uart_rx byte stream into validated fixed-length frames.
// HUNT slides a 4-byte window looking for MAGICNUMBER, PAYLOAD collects the
// remaining bytes under an inter-byte timeout, CHECK runs a bit-serial
// CRC16 (x^16+x^15+x^2+1, init 0xFFFF), and EMIT pulses frame_valid or
// crc_error for one cycle.
// Optional build macro FRAME_DECODER_STATS_EN adds saturating good/CRC-error
// frame counters; without it both counter ports read 16'h0000.
//
// Byte input handshake: there is no back-pressure. rx_data is valid exactly
// in the cycle rx_data_ready is high. A byte arriving while the decoder is in
// CHECK or EMIT is parked in a one-byte pending register and replayed on the
// first HUNT cycle; a second byte arriving while one is parked is dropped and
// reported with a one-cycle overrun pulse.
module uart_frame_decoder #(
    parameter int          FRAME_LENGTH   = 8,
    parameter logic [31:0] MAGICNUMBER    = 32'hDABBAD00,
    parameter int          TIMEOUT_CYCLES = 16000
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      rx_data_ready,
    input  logic [7:0]                rx_data,
    output logic                      frame_valid,
    output logic [8*FRAME_LENGTH-1:0] frame_data,
    output logic                      crc_error,
    output logic                      busy,
    output logic                      overrun,
    output logic [15:0]               good_count,
    output logic [15:0]               crc_err_count,
    output logic [1:0]                dbg_state
);

    localparam int CRC_BITS = 8 * (FRAME_LENGTH - 2);
    localparam int BIT_W    = $clog2(CRC_BITS);
    localparam int IDX_W    = $clog2(FRAME_LENGTH);
    localparam int TMR_W    = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    state_t                    r_state;
    logic [31:0]               r_window;
    logic [7:0]                r_buf [FRAME_LENGTH];
    logic [IDX_W-1:0]          r_idx;
    logic [TMR_W-1:0]          r_timer;
    logic [15:0]               r_crc;
    logic [BIT_W-1:0]          r_bit;
    logic                      r_pend;
    logic [7:0]                r_pend_byte;
    logic                      r_frame_valid;
    logic                      r_crc_error;
    logic                      r_overrun;
    logic [8*FRAME_LENGTH-1:0] r_frame_data;

    logic        w_have_byte;
    logic [7:0]  w_byte;
    logic [31:0] w_window_next;
    logic        w_crc_bit;
    logic        w_crc_fb;
    logic [15:0] w_crc_next;
    logic        w_crc_pass;
    logic        w_last_byte;
    logic        w_timeout;
    logic        w_rx_parked;

    // A parked byte takes priority over a live strobe; the live one is parked in turn.
    assign w_have_byte   = r_pend | rx_data_ready;
    assign w_byte        = r_pend ? r_pend_byte : rx_data;
    assign w_window_next = {r_window[23:0], w_byte};

    // Serial CRC walks D = {byte[N-3],...,byte[0]} from its MSB down to bit 0.
    assign w_crc_bit  = r_buf[r_bit[BIT_W-1:3]][r_bit[2:0]];
    assign w_crc_fb   = r_crc[15] ^ w_crc_bit;
    assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h8005 : 16'h0000);
    assign w_crc_pass = (r_crc == {r_buf[FRAME_LENGTH-2], r_buf[FRAME_LENGTH-1]});

    assign w_last_byte = (r_idx == IDX_W'(FRAME_LENGTH - 1));
    assign w_timeout   = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign w_rx_parked = (r_state == S_CHECK) || (r_state == S_EMIT);

    // Frame FSM: header hunt, payload collection, serial CRC check and emit.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state       <= S_HUNT;
            r_window      <= '0;
            r_idx         <= '0;
            r_timer       <= '0;
            r_crc         <= 16'hFFFF;
            r_bit         <= '0;
            r_pend        <= 1'b0;
            r_pend_byte   <= '0;
            r_frame_valid <= 1'b0;
            r_crc_error   <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_data  <= '0;
            for (int i = 0; i < FRAME_LENGTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_frame_valid <= 1'b0;
            r_crc_error   <= 1'b0;
            r_overrun     <= 1'b0;

            // Pending register: fill while busy checking, drain in HUNT/PAYLOAD.
            if (w_rx_parked) begin
                if (rx_data_ready) begin
                    if (r_pend) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_pend      <= 1'b1;
                        r_pend_byte <= rx_data;
                    end
                end
            end else if (r_pend) begin
                r_pend      <= rx_data_ready;
                r_pend_byte <= rx_data;
            end

            case (r_state)
                S_HUNT: begin
                    if (w_have_byte) begin
                        r_window <= w_window_next;
                        if (w_window_next == MAGICNUMBER) begin
                            r_buf[0] <= MAGICNUMBER[31:24];
                            r_buf[1] <= MAGICNUMBER[23:16];
                            r_buf[2] <= MAGICNUMBER[15:8];
                            r_buf[3] <= MAGICNUMBER[7:0];
                            r_idx    <= IDX_W'(4);
                            r_timer  <= '0;
                            r_state  <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_have_byte) begin
                        r_buf[r_idx] <= w_byte;
                        r_idx        <= r_idx + 1'b1;
                        r_timer      <= '0;
                        if (w_last_byte) begin
                            r_crc   <= 16'hFFFF;
                            r_bit   <= BIT_W'(CRC_BITS - 1);
                            r_state <= S_CHECK;
                        end
                    end else if (w_timeout) begin
                        r_window <= '0;
                        r_state  <= S_HUNT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_crc <= w_crc_next;
                    r_bit <= r_bit - 1'b1;
                    if (r_bit == '0) begin
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (w_crc_pass) begin
                        r_frame_valid <= 1'b1;
                        for (int i = 0; i < FRAME_LENGTH; i++) begin
                            r_frame_data[8*i +: 8] <= r_buf[i];
                        end
                    end else begin
                        r_crc_error <= 1'b1;
                    end
                    r_window <= '0;
                    r_state  <= S_HUNT;
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end

    assign frame_valid = r_frame_valid;
    assign frame_data  = r_frame_data;
    assign crc_error   = r_crc_error;
    assign overrun     = r_overrun;
    assign busy        = (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    assign dbg_state   = r_state;

`ifdef FRAME_DECODER_STATS_EN
    logic [15:0] r_good_count;
    logic [15:0] r_crc_err_count;

    // Saturating frame statistics, stepped on the same edge as the result pulses.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_good_count    <= '0;
            r_crc_err_count <= '0;
        end else if (r_state == S_EMIT) begin
            if (w_crc_pass && (r_good_count != 16'hFFFF)) begin
                r_good_count <= r_good_count + 16'd1;
            end
            if (!w_crc_pass && (r_crc_err_count != 16'hFFFF)) begin
                r_crc_err_count <= r_crc_err_count + 16'd1;
            end
        end
    end

    assign good_count    = r_good_count;
    assign crc_err_count = r_crc_err_count;
`else
    assign good_count    = 16'h0000;
    assign crc_err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: directed byte streams, a byte-level model of
// the framing rules that schedules expected pulses, and a per-cycle compare.
`timescale 1ns/1ps
module tb_uart_frame_decoder;

    localparam int          N       = 8;
    localparam int          TIMEOUT = 16000;
    localparam int          LAT     = 8 * (N - 2) + 2;
    localparam logic [31:0] MAGIC   = 32'hDABBAD00;
`ifdef FRAME_DECODER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          rx_data_ready = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          frame_valid;
    logic [8*N-1:0] frame_data;
    logic          crc_error;
    logic          busy;
    logic          overrun;
    logic [15:0]   good_count;
    logic [15:0]   crc_err_count;
    logic [1:0]    dbg_state;

    uart_frame_decoder dut (
        .CLK          (CLK),
        .reset        (reset),
        .rx_data_ready(rx_data_ready),
        .rx_data      (rx_data),
        .frame_valid  (frame_valid),
        .frame_data   (frame_data),
        .crc_error    (crc_error),
        .busy         (busy),
        .overrun      (overrun),
        .good_count   (good_count),
        .crc_err_count(crc_err_count),
        .dbg_state    (dbg_state)
    );

    // Clock / cycle index. Window k = time between posedge k and posedge k+1.
    always #31 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]    m_win;
    bit             m_collect;
    bq_t            m_frame;
    int             m_last_cyc;
    int             m_busy_until;
    bit             m_pend;
    logic [7:0]     m_pend_b;
    int             m_pend_cyc;
    logic [8*N-1:0] m_frame_data;
    logic [15:0]    m_good;
    logic [15:0]    m_err;
    int             ev_fv_q[$];
    logic [8*N-1:0] ev_data_q[$];
    int             ev_ce_q[$];
    int             ev_ov_q[$];

    function automatic logic [15:0] crc16(input bq_t d);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (d[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ d[i][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        return c;
    endfunction

    // CRC covers D = {byte[N-3],...,byte[0]} sent MSB first: last data byte first.
    function automatic logic [15:0] frame_crc(input bq_t f);
        bq_t ser;
        ser = {};
        for (int i = N - 3; i >= 0; i--) ser.push_back(f[i]);
        return crc16(ser);
    endfunction

    task automatic model_reset();
        m_win = '0; m_collect = 0; m_frame = {}; m_last_cyc = 0;
        m_busy_until = -1; m_pend = 0; m_pend_b = '0; m_pend_cyc = 0;
        m_frame_data = '0; m_good = '0; m_err = '0;
        ev_fv_q = {}; ev_data_q = {}; ev_ce_q = {}; ev_ov_q = {};
    endtask

    task automatic model_process(input logic [7:0] b, input int eff);
        logic [15:0]    c;
        logic [8*N-1:0] flat;
        if (m_collect && (eff - m_last_cyc > TIMEOUT)) begin
            m_collect = 0;
            m_win     = '0;
            m_frame   = {};
        end
        if (!m_collect) begin
            m_win = {m_win[23:0], b};
            if (m_win == MAGIC) begin
                m_frame = {};
                for (int i = 3; i >= 0; i--) m_frame.push_back(m_win[8*i +: 8]);
                m_collect  = 1;
                m_last_cyc = eff;
            end
        end else begin
            m_frame.push_back(b);
            m_last_cyc = eff;
            if (m_frame.size() == N) begin
                c = frame_crc(m_frame);
                flat = '0;
                for (int i = 0; i < N; i++) flat[8*i +: 8] = m_frame[i];
                if (c == {m_frame[N-2], m_frame[N-1]}) begin
                    ev_fv_q.push_back(eff + LAT);
                    ev_data_q.push_back(flat);
                end else begin
                    ev_ce_q.push_back(eff + LAT);
                end
                m_busy_until = eff + LAT - 1;
                m_collect = 0;
                m_win     = '0;
                m_frame   = {};
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int at);
        int eff;
        if (at <= m_busy_until) begin
            if (!m_pend) begin
                m_pend     = 1;
                m_pend_b   = b;
                m_pend_cyc = m_busy_until + 1;
            end else begin
                ev_ov_q.push_back(at + 1);
            end
        end else begin
            eff = at;
            if (m_pend) begin
                model_process(m_pend_b, m_pend_cyc);
                m_pend = 0;
                if (eff <= m_pend_cyc) eff = m_pend_cyc + 1;
            end
            model_process(b, eff);
        end
    endtask

    // ---------------- scoreboard compare, every cycle ----------------
    logic exp_fv, exp_ce, exp_ov;
    always @(negedge CLK) begin
        if (chk_en) begin
            exp_fv = 1'b0; exp_ce = 1'b0; exp_ov = 1'b0;
            if (ev_fv_q.size() > 0 && ev_fv_q[0] == cyc) begin
                exp_fv = 1'b1;
                void'(ev_fv_q.pop_front());
                m_frame_data = ev_data_q.pop_front();
                if (m_good != 16'hFFFF) m_good = m_good + 16'd1;
            end
            if (ev_ce_q.size() > 0 && ev_ce_q[0] == cyc) begin
                exp_ce = 1'b1;
                void'(ev_ce_q.pop_front());
                if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
            end
            if (ev_ov_q.size() > 0 && ev_ov_q[0] == cyc) begin
                exp_ov = 1'b1;
                void'(ev_ov_q.pop_front());
            end
            check("sb_frame_valid", frame_valid, exp_fv);
            check("sb_crc_error", crc_error, exp_ce);
            check("sb_overrun", overrun, exp_ov);
            check("sb_frame_data", frame_data, m_frame_data);
            check("sb_good_count", good_count, STATS ? m_good : 16'h0000);
            check("sb_crc_err_count", crc_err_count, STATS ? m_err : 16'h0000);
        end
    end

    // ---------------- driver tasks ----------------
    int last_cyc;

    task automatic send_byte(input logic [7:0] b);
        rx_data_ready = 1'b1;
        rx_data       = b;
        last_cyc      = cyc;
        model_byte(b, cyc);
        @(posedge CLK);
        #1;
        rx_data_ready = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    task automatic send_seq(input bq_t s, input int gap);
        foreach (s[i]) begin
            send_byte(s[i]);
            if (i != s.size() - 1) idle(gap);
        end
    endtask

    function automatic bq_t make_frame(input logic [7:0] p4, input logic [7:0] p5,
                                       input logic [7:0] x7);
        bq_t         f;
        logic [15:0] c;
        f = {8'hDA, 8'hBB, 8'hAD, 8'h00, p4, p5};
        c = frame_crc(f);
        f.push_back(c[15:8]);
        f.push_back(c[7:0] ^ x7);
        return f;
    endfunction

    task automatic at_window(input int w);
        @(negedge CLK);
        while (cyc < w) @(negedge CLK);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge CLK);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    int          t;
    bq_t         f;
    bq_t         s;
    logic [15:0] gold;

    initial begin
        model_reset();
        reset = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state and model pin (CRC-16/CMS check value of "123456789").
        at_window(cyc);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_data", frame_data, 0);
        check("rst_busy", busy, 0);
        check("rst_good_count", good_count, 0);
        s = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_crc_pin", crc16(s), 16'hAEE7);

        // 1: good frame, 160-cycle spacing, latency 50.
        f = make_frame(8'h12, 8'h34, 8'h00);
        gold = {f[6], f[7]};
        send_seq(f, 159);
        t = last_cyc;
        at_window(t + 10);
        check("t1_busy_in_check", busy, 1);
        at_window(t + LAT - 1);
        check("t1_no_early_valid", frame_valid, 0);
        at_window(t + LAT);
        check("t1_valid_at_50", frame_valid, 1);
        check("t1_byte4", frame_data[39:32], 8'h12);
        check("t1_byte5", frame_data[47:40], 8'h34);
        check("t1_magic_bytes", frame_data[31:0], 32'h00ADBBDA);
        check("t1_good_count", good_count, STATS ? 16'd1 : 16'd0);
        check("t1_busy_after", busy, 0);

        // 2: corrupted CRC low byte.
        idle(20);
        send_seq(make_frame(8'h12, 8'h34, 8'h01), 159);
        t = last_cyc;
        at_window(t + LAT);
        check("t2_crc_error_at_50", crc_error, 1);
        check("t2_no_valid", frame_valid, 0);
        check("t2_data_kept_crc_lo", frame_data[63:56], gold[7:0]);
        check("t2_data_kept_byte4", frame_data[39:32], 8'h12);
        check("t2_crc_err_count", crc_err_count, STATS ? 16'd1 : 16'd0);

        // 3: junk prefix with overlapping DA, payload made of magic bytes.
        idle(20);
        f = make_frame(8'hDA, 8'hBB, 8'h00);
        s = {8'h00, 8'hDA};
        foreach (f[i]) s.push_back(f[i]);
        send_seq(s, 159);
        t = last_cyc;
        at_window(t + LAT);
        check("t3_valid", frame_valid, 1);
        check("t3_byte4", frame_data[39:32], 8'hDA);
        idle(20);
        send_seq({8'hAD, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 159);

        // 4: partial frame then timeout, then a good frame.
        idle(20);
        send_seq({8'hDA, 8'hBB, 8'hAD, 8'h00, 8'h12}, 159);
        idle(TIMEOUT + 5);
        at_window(cyc);
        check("t4_busy_dropped", busy, 0);
        send_seq(make_frame(8'h56, 8'h78, 8'h00), 159);
        t = last_cyc;
        at_window(t + LAT);
        check("t4_valid", frame_valid, 1);
        check("t4_byte4", frame_data[39:32], 8'h56);

        // 5: two strobes during CHECK: DA parked, BB dropped.
        idle(20);
        send_seq(make_frame(8'h9A, 8'hBC, 8'h00), 159);
        t = last_cyc;
        idle(9);
        send_byte(8'hDA);
        idle(4);
        send_byte(8'hBB);
        at_window(t + 16);
        check("t5_overrun", overrun, 1);
        at_window(t + LAT);
        check("t5_valid", frame_valid, 1);
        idle(20);
        f = make_frame(8'hC3, 8'h3C, 8'h00);
        void'(f.pop_front());
        send_seq(f, 159);
        t = last_cyc;
        at_window(t + LAT);
        check("t5_parked_da_valid", frame_valid, 1);
        check("t5_byte4", frame_data[39:32], 8'hC3);

        // 6: reset mid-payload, then a clean frame.
        idle(20);
        send_seq({8'hDA, 8'hBB, 8'hAD, 8'h00, 8'h12, 8'h34}, 159);
        idle(20);
        apply_reset();
        at_window(cyc);
        check("t6_rst_frame_data", frame_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_good_count", good_count, 0);
        check("t6_rst_crc_err_count", crc_err_count, 0);
        send_seq(make_frame(8'h12, 8'h34, 8'h00), 159);
        t = last_cyc;
        at_window(t + LAT);
        check("t6_valid", frame_valid, 1);
        check("t6_good_count", good_count, STATS ? 16'd1 : 16'd0);

        idle(60);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
